// File: rtl/calc_pkg.sv
// Shared definitions for the operand entry controller and the add/subtract display stage.
package calc_pkg;

  localparam int OPERAND_W = 4;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    SHOW     = 2'b11
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge press detector for one raw button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Level flips only on the last of DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer, counter, debounced level and edge history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/operand_entry_controller.sv
// Collects operand A, operand B and the operation select through debounced enter/clear buttons.
module operand_entry_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 op_sw,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic                 S,
  output logic                 operands_valid,
  output logic                 load_pulse,
  output logic [1:0]           state_code
);

  logic                 enter_evt_s;
  logic                 clear_evt_s;
  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic                 s_q, s_d;
  logic                 valid_q, valid_d;
  logic                 load_q, load_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_enter),
    .press_o(enter_evt_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_clear),
    .press_o(clear_evt_s)
  );

  // Next state and captured values; clear discards a coincident enter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    load_d  = 1'b0;
    if (clear_evt_s) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      s_d     = OP_SUB;
    end else if (enter_evt_s) begin
      case (state_q)
        ENTER_A: begin
          a_d     = sw;
          state_d = ENTER_B;
        end
        ENTER_B: begin
          b_d     = sw;
          state_d = ENTER_OP;
        end
        ENTER_OP: begin
          s_d     = op_sw;
          state_d = SHOW;
          load_d  = 1'b1;
        end
        SHOW: begin
          state_d = ENTER_A;
        end
        default: begin
          state_d = ENTER_A;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == SHOW);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= OP_SUB;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      load_q  <= load_d;
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign S              = s_q;
  assign operands_valid = valid_q;
  assign load_pulse     = load_q;
  assign state_code     = state_q;

endmodule
